// File: rtl/wb_mem_tester.sv
// Wishbone memory tester: writes an address^seed pattern across a word range,
// reads it back and reports the first mismatch, bus error/retry or timeout.
module wb_mem_tester #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] word_cnt,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  status,
  output logic [31:0] err_adr,
  output logic [31:0] err_exp,
  output logic [31:0] err_got,
  output logic [31:0] adr,
  output logic [31:0] dout,
  output logic        cyc,
  output logic        stb,
  output logic [3:0]  sel,
  output logic        we,
  input  logic [31:0] din,
  input  logic        ack,
  input  logic        err,
  input  logic        rty
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_WGAP   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_RGAP   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_MISMATCH = 2'b01;
  localparam logic [1:0] ST_BUS      = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  // The counter starts at 0 on the entry edge, so hitting TIMEOUT-1 on a
  // sampling edge means the request has been held for exactly TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  st_q, st_d;
  logic [31:0] base_q, base_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] err_adr_q, err_adr_d;
  logic [31:0] err_exp_q, err_exp_d;
  logic [31:0] err_got_q, err_got_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dout_q, dout_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;

  logic [31:0] pat;
  logic [31:0] adr_inc;
  logic [16:0] idx_inc;
  logic        more;
  logic        abort;

  assign pat     = adr_q ^ seed_q;
  assign adr_inc = adr_q + 32'd4;
  assign idx_inc = {1'b0, idx_q} + 17'd1;
  assign more    = idx_inc < {1'b0, cnt_q};

  always_comb begin
    st_d      = st_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    status_d  = status_q;
    err_adr_d = err_adr_q;
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;
    adr_d     = adr_q;
    dout_d    = dout_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    sel_d     = sel_q;
    we_d      = we_q;
    abort     = 1'b0;

    case (st_q)
      S_IDLE: begin
        if (start) begin
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          status_d  = ST_OK;
          err_adr_d = '0;
          err_exp_d = '0;
          err_got_d = '0;
          if (word_cnt == '0) begin
            st_d = S_FINISH;
          end else begin
            base_d = base_adr;
            cnt_d  = word_cnt;
            seed_d = seed;
            idx_d  = '0;
            busy_d = 1'b1;
            adr_d  = base_adr;
            dout_d = base_adr ^ seed;
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = 1'b1;
            sel_d  = '1;
            wait_d = '0;
            st_d   = S_WRITE;
          end
        end
      end
      S_WRITE, S_READ: begin
        if (err || rty) begin
          abort    = 1'b1;
          status_d = ST_BUS;
        end else if (ack) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = '0;
          if (st_q == S_WRITE) begin
            st_d = S_WGAP;
          end else if (din != pat) begin
            err_adr_d = adr_q;
            err_exp_d = pat;
            err_got_d = din;
            status_d  = ST_MISMATCH;
            st_d      = S_FINISH;
          end else begin
            st_d = S_RGAP;
          end
        end else if (wait_q == WAIT_LAST) begin
          abort    = 1'b1;
          status_d = ST_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WGAP: begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        sel_d  = '1;
        wait_d = '0;
        if (more) begin
          idx_d  = idx_inc[15:0];
          adr_d  = adr_inc;
          dout_d = adr_inc ^ seed_q;
          we_d   = 1'b1;
          st_d   = S_WRITE;
        end else begin
          idx_d = '0;
          adr_d = base_q;
          we_d  = 1'b0;
          st_d  = S_READ;
        end
      end
      S_RGAP: begin
        if (more) begin
          idx_d  = idx_inc[15:0];
          adr_d  = adr_inc;
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          sel_d  = '1;
          wait_d = '0;
          st_d   = S_READ;
        end else begin
          st_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (status_q == ST_OK);
        fail_d = (status_q != ST_OK);
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase

    if (abort) begin
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      we_d      = 1'b0;
      sel_d     = '0;
      err_adr_d = adr_q;
      err_exp_d = pat;
      err_got_d = '0;
      st_d      = S_FINISH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      status_q  <= '0;
      err_adr_q <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
      adr_q     <= '0;
      dout_q    <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      sel_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      status_q  <= status_d;
      err_adr_q <= err_adr_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
      adr_q     <= adr_d;
      dout_q    <= dout_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign status  = status_q;
  assign err_adr = err_adr_q;
  assign err_exp = err_exp_q;
  assign err_got = err_got_q;
  assign adr     = adr_q;
  assign dout    = dout_q;
  assign cyc     = cyc_q;
  assign stb     = stb_q;
  assign sel     = sel_q;
  assign we      = we_q;

endmodule

// File: doc/wb_mem_tester.md
WB_MEM_TESTER -- requirements
Module: wb_mem_tester

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; it is the maximum number of cycles to wait for a bus termination, range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port start, input, 1 bit: begin a test; sampled only in IDLE.
REQ-005 SHALL have port base_adr, input, 32 bits: byte address of the first word; sampled at start.
REQ-006 SHALL have port word_cnt, input, 16 bits: number of 32-bit words to test; sampled at start.
REQ-007 SHALL have port seed, input, 32 bits: pattern seed; sampled at start.
REQ-008 SHALL have outputs busy (1 bit), done (1 bit), pass (1 bit), fail (1 bit) and status (2 bits): 00 ok, 01 mismatch, 10 bus err/rty, 11 timeout.
REQ-009 SHALL have outputs err_adr, err_exp and err_got, 32 bits each: the first failing address, the expected data and the received data.
REQ-010 SHALL have Wishbone master outputs adr (32), dout (32), cyc (1), stb (1), sel (4), we (1).
REQ-011 SHALL have Wishbone master inputs din (32), ack (1), err (1), rty (1).
REQ-012 SHALL drive every output from a register.

Function
REQ-013 SHALL implement states IDLE, WRITE, WGAP, READ, RGAP, FINISH.
REQ-014 SHALL behave as follows in IDLE:
- start=1 and word_cnt=0: go to FINISH with status=00; no bus cycle is issued.
- start=1 and word_cnt>0: latch the inputs, clear idx, clear the previous pass/fail/status/err_*, set busy=1, go to WRITE.
REQ-015 SHALL compute the word address as adr = base_adr + 4*idx, modulo 2^32 (wraps past 0xFFFFFFFC).
REQ-016 SHALL compute the pattern as pat = adr XOR seed.
REQ-017 SHALL drive, in WRITE: cyc=stb=we=1, sel=4'hF, dout=pat. These hold until a termination is sampled.
REQ-018 SHALL on ack in WRITE: drop cyc/stb/we on that same edge and go to WGAP.
REQ-019 SHALL hold WGAP for one cycle with cyc=stb=0, then take the next step:
- idx+1 < word_cnt: idx++ and go to WRITE.
- otherwise: idx=0 and go to READ.
REQ-020 SHALL drive, in READ: cyc=stb=1, we=0, sel=4'hF.
REQ-021 SHALL on ack in READ: compare din with pat.
- Mismatch: record adr/pat/din into err_*, set status=01, go to FINISH.
- Match: go to RGAP.
REQ-022 SHALL hold RGAP for one cycle with cyc=stb=0, then take the next step:
- idx+1 < word_cnt: idx++ and go to READ.
- otherwise: go to FINISH with status=00.
REQ-023 SHALL treat err or rty sampled in WRITE or READ as an abort:
- drop cyc/stb;
- set err_adr=adr, err_exp=pat, err_got=0;
- set status=10 and go to FINISH.
- Priority when terminations coincide: err > rty > ack.
REQ-024 SHALL run an 8-bit wait counter that clears on entry to WRITE or READ and increments each cycle without a termination.
REQ-025 SHALL abort on timeout: when the wait counter reaches TIMEOUT, drop cyc/stb, set status=11 and err_adr=adr, go to FINISH.
REQ-026 SHALL in FINISH pulse done=1 for exactly one cycle, clear busy, set pass = (status==00) and fail = !pass, and return to IDLE.
REQ-027 SHALL hold pass, fail, status and err_* until the next accepted start.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL never assert stb without cyc.
REQ-030 SHALL keep we constant for the whole of a cycle.
REQ-031 SHALL keep cyc=0 for at least one cycle between consecutive transfers.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force the state to IDLE and all outputs and internal registers to 0 (cyc=stb=we=0, sel=0).
REQ-033 SHALL abandon any in-flight transfer when rst_n is asserted, with no done pulse; the first start after rst_n deasserts runs normally.

Verification
REQ-034 SHALL pass the normal case: base=0x100, cnt=4, seed=0xA5A5A5A5, zero-wait memory model.
- Expect 4 writes to 0x100/104/108/10C; first data 0xA5A5A4A5.
- Expect 4 reads of the same addresses.
- Expect done with pass=1, status=00.
REQ-035 SHALL detect a mismatch: same setup, model returns 0 on the read of 0x108.
- Expect fail=1, status=01, err_adr=0x108, err_exp=0xA5A5A4AD, err_got=0.
- Expect no read of 0x10C.
REQ-036 SHALL detect a timeout: model never acks the first write.
- Expect cyc to drop after 255 cycles, status=11, err_adr=base.
- Expect done 1 cycle later.
REQ-037 SHALL handle bus err and wrap-around:
- err asserted on read 2 -> status=10.
- base=0xFFFFFFF8, cnt=4 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-038 SHALL handle cnt=0 and reset mid-test:
- cnt=0 -> done the cycle after FINISH, pass=1, no cyc.
- rst_n low during READ -> cyc=0 immediately and no done pulse.
